ram_readback_streamer: RTL and testbench

RAM_READBACK_STREAMER -- requirements
Module: ram_readback_streamer

---
 rtl/hra_pkg.sv | 20 ++
 rtl/skid_fifo2.sv | 61 ++++++
 rtl/ram_readback_streamer.sv | 112 +++++++++++
 tb/tb_ram_readback_streamer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hra_pkg.sv
// Shared definitions for the capture/readback blocks: FSM state encoding
// and the word-width rule used to size the capture RAM data path.
package hra_pkg;

  // Readback controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } hra_state_t;

  // Depth of the output skid FIFO between the RAM and the stream sink
  localparam int SKID_DEPTH = 2;

  // One captured word holds the signed result digits plus one extra digit slot
  function automatic int word_width(input int digits, input int radix_bits);
    return (digits + 1) * radix_bits;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that decouples the fixed-latency RAM read from the
// back-pressured output stream. Head entry is presented combinationally.
module skid_fifo2
  import hra_pkg::*;
#(
  parameter int WORD_W = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] mem_reg [SKID_DEPTH];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic              wr_en;
  logic              rd_en;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle
  always_comb begin
    rd_en = pop && (count_reg != 2'd0);
    wr_en = push && ((count_reg != 2'd2) || rd_en);
  end

  // Storage entries; cleared on reset so the idle output reads as zero
  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem_reg[gi] <= '0;
      end else if (wr_en && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (wr_en) wr_ptr_reg <= ~wr_ptr_reg;
      if (rd_en) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + 2'(wr_en) - 2'(rd_en);
    end
  end

  assign rdata = mem_reg[rd_ptr_reg];
  assign full  = (count_reg == 2'd2);
  assign empty = (count_reg == 2'd0);
  assign count = count_reg;

endmodule

// File: rtl/ram_readback_streamer.sv
// Reads the capture RAM from address 0 to MAX_RAM_ADDRESS-1 and streams the
// words out over a valid/ready interface. Reads are only issued when the
// skid FIFO is guaranteed room for the returning data, so nothing is lost.
module ram_readback_streamer
  import hra_pkg::*;
#(
  parameter int NO_OF_DIGITS    = 10,
  parameter int RADIX_BITS      = 3,
  parameter int ADDRESS_WIDTH   = 14,
  parameter int MAX_RAM_ADDRESS = 4096,
  localparam int WORD_W         = word_width(NO_OF_DIGITS, RADIX_BITS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_rden,
  input  logic [WORD_W-1:0]        ram_q,
  output logic [WORD_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   word_count
);

  // One extra bit so the address and count can reach 2^ADDRESS_WIDTH
  localparam int ADDR_CNT_W = ADDRESS_WIDTH + 1;
  localparam logic [ADDR_CNT_W-1:0] MAX_ADDR = ADDR_CNT_W'(MAX_RAM_ADDRESS);
  localparam logic [ADDR_CNT_W-1:0] LAST_IDX = ADDR_CNT_W'(MAX_RAM_ADDRESS - 1);

  hra_state_t               state_reg;
  logic [ADDR_CNT_W-1:0]    addr_reg;
  logic [ADDRESS_WIDTH-1:0] last_addr_reg;
  logic                     in_flight_reg;
  logic [ADDR_CNT_W-1:0]    word_count_reg;

  logic [1:0]               fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [2:0]               occ_sum;
  logic                     issue;
  logic                     pop;

  // Read gate: after this edge's pop the FIFO plus the in-flight word must
  // leave room for the word this read will return one cycle later
  always_comb begin
    occ_sum = {1'b0, fifo_count} + {2'b00, in_flight_reg} - {2'b00, pop};
    issue   = (state_reg == STREAM) && (addr_reg < MAX_ADDR) &&
              (occ_sum <= 3'd1) && (!fifo_full || pop);
  end

  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  // Words leave in address order, so the head word's index is the transfer count
  assign out_last  = out_valid && (word_count_reg == LAST_IDX);
  assign ram_rden  = issue;
  assign ram_addr  = issue ? addr_reg[ADDRESS_WIDTH-1:0] : last_addr_reg;
  assign busy      = (state_reg == STREAM);
  assign done      = (state_reg == DONE);
  assign word_count = word_count_reg;

  // Controller FSM with read address, in-flight flag and transfer counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      last_addr_reg  <= '0;
      in_flight_reg  <= 1'b0;
      word_count_reg <= '0;
    end else begin
      in_flight_reg <= issue;
      if (issue) begin
        addr_reg      <= addr_reg + ADDR_CNT_W'(1);
        last_addr_reg <= addr_reg[ADDRESS_WIDTH-1:0];
      end
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg      <= STREAM;
            addr_reg       <= '0;
            word_count_reg <= '0;
          end
        end
        STREAM: begin
          if (pop) begin
            word_count_reg <= word_count_reg + ADDR_CNT_W'(1);
            if (out_last) state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // RAM data lands in the FIFO the cycle after its read strobe
  skid_fifo2 #(
    .WORD_W (WORD_W)
  ) u_skid_fifo2 (
    .clk   (clk),
    .reset (reset),
    .push  (in_flight_reg),
    .wdata (ram_q),
    .pop   (pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_ram_readback_streamer.sv
// Bench for ram_readback_streamer: a behavioural RAM plus an in-order
// scoreboard (word i of a pass must be RAM[i], last flag on i = MAX-1).
module tb_ram_readback_streamer;
  localparam int ND   = 10;
  localparam int RB   = 3;
  localparam int AW   = 3;
  localparam int MAXA = 8;
  localparam int WW   = (ND + 1) * RB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          start1 = 1'b0;
  logic [AW-1:0] ram_addr, ram_addr1;
  logic          ram_rden, ram_rden1;
  logic [WW-1:0] ram_q, ram_q1, out_data, out_data1;
  logic          out_valid, out_valid1, out_last, out_last1;
  logic          out_ready = 1'b1;
  logic          out_ready1 = 1'b1;
  logic          busy, busy1, done, done1;
  logic [AW:0]   word_count, word_count1;

  logic [WW-1:0] ram0 [MAXA];
  logic [WW-1:0] ram1 [1];

  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  xfer_idx, rd_exp, rd_pulses, first_rden_cyc, first_valid_cyc, last_xfer_cyc;
  bit  mon_en = 1'b0;
  bit  prev_stall = 1'b0;

  ram_readback_streamer #(
    .NO_OF_DIGITS(ND), .RADIX_BITS(RB), .ADDRESS_WIDTH(AW), .MAX_RAM_ADDRESS(MAXA)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ram_addr(ram_addr), .ram_rden(ram_rden),
    .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .word_count(word_count)
  );

  ram_readback_streamer #(
    .NO_OF_DIGITS(ND), .RADIX_BITS(RB), .ADDRESS_WIDTH(AW), .MAX_RAM_ADDRESS(1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ram_addr(ram_addr1), .ram_rden(ram_rden1),
    .ram_q(ram_q1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_last(out_last1), .busy(busy1), .done(done1), .word_count(word_count1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAMs with one-cycle read latency
  always @(posedge clk) if (ram_rden) ram_q <= ram0[ram_addr];
  always @(posedge clk) if (ram_rden1) ram_q1 <= ram1[0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic mon_reset();
    xfer_idx = 0; rd_exp = 0; rd_pulses = 0;
    first_rden_cyc = -1; first_valid_cyc = -1; last_xfer_cyc = -1;
    prev_stall = 1'b0; mon_en = 1'b1;
  endtask

  // Scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) check("valid_held", out_valid, 1);
      if (ram_rden) begin
        if (first_rden_cyc < 0) first_rden_cyc = cyc;
        check("rd_in_range", rd_exp < MAXA, 1);
        check("rd_addr", ram_addr, rd_exp[AW-1:0]);
        rd_exp++;
        rd_pulses++;
      end
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (xfer_idx < MAXA) begin
          check("data", out_data, ram0[xfer_idx]);
          check("last", out_last, xfer_idx == MAXA - 1);
        end else begin
          check("extra_word", xfer_idx, MAXA - 1);
        end
        if (out_ready) begin
          $display("xfer %0d data=%0h last=%0b cycle=%0d", xfer_idx, out_data, out_last, cyc);
          xfer_idx++;
          last_xfer_cyc = cyc;
        end
      end
      prev_stall = out_valid && !out_ready;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_rden"}, ram_rden, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_count"}, word_count, 0);
  endtask

  // mode: 0 ready always, 1 ready one cycle in three, 2 random ready
  task automatic run_pass(input int mode, input int stall_cycles, input int reset_after,
                          input bit start_mid);
    int start_cyc;
    int budget;
    mon_reset();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    for (budget = 0; budget < 400 && xfer_idx < MAXA; budget++) begin
      if (stall_cycles > 0 && budget == stall_cycles) check("stall_reads", rd_pulses, 2);
      if (budget < stall_cycles) out_ready = 1'b0;
      else if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = (budget % 3 == 0);
      else out_ready = 1'($urandom_range(0, 1));
      start = start_mid && (budget == 4);
      if (reset_after > 0 && xfer_idx == reset_after) begin
        reset = 1'b1;
        mon_en = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("pass_words", xfer_idx, MAXA);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_count", word_count, MAXA);
    check("end_valid", out_valid, 0);
    check("end_rden", ram_rden, 0);
    check("end_reads", rd_pulses, MAXA);
    if (mode == 0 && stall_cycles == 0) begin
      check("lat_rden", first_rden_cyc - start_cyc, 0);
      check("lat_valid", first_valid_cyc - start_cyc, 2);
      check("lat_last", last_xfer_cyc - start_cyc, 9);
    end
    @(posedge clk); #1;
    check("done_hold", done, 1);
    mon_en = 1'b0;
  endtask

  initial begin
    int n1;
    for (int i = 0; i < MAXA; i++) ram0[i] = WW'(3 * i + 1);
    ram1[0] = WW'(5);

    #2 reset = 1'b1;
    #1 check_all_zero("rst_init");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_pass(0, 0, 0, 1'b0);   // full rate, latency
    run_pass(1, 0, 0, 1'b0);   // ready one cycle in three
    run_pass(0, 20, 0, 1'b0);  // long initial stall
    run_pass(2, 0, 3, 1'b0);   // reset after the third transfer
    run_pass(2, 0, 0, 1'b0);   // restart from address 0 after reset
    run_pass(2, 0, 0, 1'b1);   // stray start during streaming
    run_pass(0, 0, 0, 1'b0);   // start from DONE repeats the pass

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < MAXA; i++) ram0[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
      run_pass(2, 0, 0, 1'($urandom_range(0, 1)));
    end

    // Single-word pass on the one-address instance
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_rden1) check("s6_addr", ram_addr1, 0);
      if (out_valid1) begin
        check("s6_data", out_data1, 5);
        check("s6_last", out_last1, 1);
        $display("xfer1 %0d data=%0h last=%0b cycle=%0d", n1, out_data1, out_last1, cyc);
        n1++;
      end
    end
    check("s6_words", n1, 1);
    check("s6_count", word_count1, 1);
    check("s6_done", done1, 1);
    check("s6_busy", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
